// File: rtl/hamming_tmr_writer.sv
// Triple-redundant Hamming(7,4) storage word with a periodic majority-vote scrubber.
// Writes load all three copies; the scrubber votes, corrects, re-encodes and rewrites them.
module hamming_tmr_writer #(
    parameter int unsigned SCRUB_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       scrub_en,
    input  logic       inj_en,
    input  logic [1:0] inj_copy,
    input  logic [2:0] inj_bit,
    output logic [6:0] copy_1,
    output logic [6:0] copy_2,
    output logic [6:0] copy_3,
    output logic       scrub_busy,
    output logic       scrub_fix,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {IDLE, VOTE, FIX} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(SCRUB_PERIOD - 1);

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[0] ^ c[1] ^ c[2] ^ c[3],
                c[0] ^ c[1] ^ c[4] ^ c[5],
                c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    // Syndrome k names bit 7-k; zero means the word is already a codeword.
    function automatic logic [6:0] correct(input logic [6:0] c);
        logic [2:0] s;
        s = syndrome(c);
        return (s == 3'd0) ? c : (c ^ (7'b1 << (3'd7 - s)));
    endfunction

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [6:0]  copy_q [3];
    logic [6:0]  copy_d [3];
    logic [6:0]  maj_q, maj_d;
    logic [7:0]  fault_q, fault_d;
    logic        fix_q, fix_d;
    logic        wr_ready_q, busy_q;

    logic        wr_take;
    logic        inj_hit;
    logic        scrub_go;
    logic [6:0]  inj_mask;
    logic [6:0]  fixed_word;
    logic [6:0]  corrected;
    logic        any_diff;

    always_comb begin
        wr_take    = (state_q == IDLE) && wr_valid;
        inj_hit    = (state_q == IDLE) && inj_en && (inj_copy != 2'd0) &&
                     (inj_bit != 3'd7) && !wr_take;
        scrub_go   = (state_q == IDLE) && scrub_en && (timer_q == TIMER_LAST) &&
                     !wr_take && !inj_hit;
        inj_mask   = 7'b1 << inj_bit;
        corrected  = correct(maj_q);
        fixed_word = encode({corrected[4], corrected[2], corrected[1], corrected[0]});
        any_diff   = (copy_q[0] != fixed_word) || (copy_q[1] != fixed_word) ||
                     (copy_q[2] != fixed_word);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        timer_d = timer_q;
        copy_d  = copy_q;
        maj_d   = maj_q;
        fault_d = fault_q;
        fix_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_take) begin
                    for (int i = 0; i < 3; i++) copy_d[i] = encode(wr_data);
                    timer_d = '0;
                end else begin
                    for (int i = 0; i < 3; i++)
                        if (inj_hit && (inj_copy == 2'(i + 1))) copy_d[i] = copy_q[i] ^ inj_mask;
                    if (!scrub_en) begin
                        timer_d = '0;
                    end else if (scrub_go) begin
                        state_d = VOTE;
                        timer_d = '0;
                    end else if (timer_q != TIMER_LAST) begin
                        // An injection that wins the start edge leaves the timer parked.
                        timer_d = timer_q + 16'd1;
                    end
                end
            end
            VOTE: begin
                maj_d   = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) |
                          (copy_q[1] & copy_q[2]);
                state_d = FIX;
            end
            FIX: begin
                for (int i = 0; i < 3; i++) copy_d[i] = fixed_word;
                fix_d = any_diff;
                if (any_diff && (fault_q != 8'hFF)) fault_d = fault_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            // NOTE: the three copies are a tiny register array, so resetting them is cheap
            // and gives a defined codeword (7'h00 = encode(0)) out of reset.
            for (int i = 0; i < 3; i++) copy_q[i] <= '0;
            maj_q      <= '0;
            fault_q    <= '0;
            fix_q      <= 1'b0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            copy_q     <= copy_d;
            maj_q      <= maj_d;
            fault_q    <= fault_d;
            fix_q      <= fix_d;
            wr_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign copy_1     = copy_q[0];
    assign copy_2     = copy_q[1];
    assign copy_3     = copy_q[2];
    assign wr_ready   = wr_ready_q;
    assign scrub_busy = busy_q;
    assign scrub_fix  = fix_q;
    assign fault_cnt  = fault_q;

endmodule
